// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential accumulator ALU: opcode encoding and FSM states.
package alu_seq_pkg;

  localparam int OPCODE_W = 4;

  // Opcodes 0-7 keep the legacy combinational ALU encoding; 8-15 are extensions.
  typedef enum logic [OPCODE_W-1:0] {
    OP_PASS0 = 4'd0,
    OP_PASS1 = 4'd1,
    OP_ADD   = 4'd2,
    OP_AND   = 4'd3,
    OP_XOR   = 4'd4,
    OP_LDA   = 4'd5,
    OP_PASS6 = 4'd6,
    OP_PASS7 = 4'd7,
    OP_SUB   = 4'd8,
    OP_OR    = 4'd9,
    OP_ADC   = 4'd10,
    OP_SHL   = 4'd11,
    OP_SHR   = 4'd12,
    OP_MUL   = 4'd13,
    OP_CLR   = 4'd14,
    OP_NOP   = 4'd15
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MUL   = 2'd2
  } state_t;

  // True for the two opcodes that may run as iterative shifts.
  function automatic logic is_shift(input opcode_t op);
    return (op == OP_SHL) || (op == OP_SHR);
  endfunction

endpackage

// File: rtl/alu_seq_core.sv
// Combinational evaluator for every single-cycle opcode. Opcodes that the top
// runs iteratively (SHL/SHR/MUL) fall through here as "hold", which is also
// exactly what a zero-distance shift or a MUL without a multiplier needs.
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [WIDTH-1:0]    accum,
  input  logic [WIDTH-1:0]    data,
  input  logic                carry,
  output logic [WIDTH-1:0]    nxt_accum,
  output logic                nxt_carry
);

  logic [WIDTH:0] add_w;
  logic [WIDTH:0] adc_w;
  logic [WIDTH:0] sub_w;

  // One extra bit on each path carries the carry-out / borrow.
  assign add_w = {1'b0, accum} + {1'b0, data};
  assign adc_w = add_w + {{WIDTH{1'b0}}, carry};
  assign sub_w = {1'b0, accum} - {1'b0, data};

  // Select the result for the decoded opcode; default holds accum and carry.
  always_comb begin
    nxt_accum = accum;
    nxt_carry = carry;
    case (opcode_t'(opcode))
      OP_ADD: begin
        nxt_accum = add_w[WIDTH-1:0];
        nxt_carry = add_w[WIDTH];
      end
      OP_ADC: begin
        nxt_accum = adc_w[WIDTH-1:0];
        nxt_carry = adc_w[WIDTH];
      end
      OP_SUB: begin
        nxt_accum = sub_w[WIDTH-1:0];
        nxt_carry = sub_w[WIDTH];
      end
      OP_AND: nxt_accum = accum & data;
      OP_XOR: nxt_accum = accum ^ data;
      OP_OR:  nxt_accum = accum | data;
      OP_LDA: nxt_accum = data;
      OP_CLR: begin
        nxt_accum = '0;
        nxt_carry = 1'b0;
      end
      default: begin
        nxt_accum = accum;
        nxt_carry = carry;
      end
    endcase
  end

endmodule

// File: rtl/alu_seq_acc.sv
// Accumulator ALU with carry/zero flags, valid/ready input and iterative
// shift (one bit per cycle) and shift-add multiply. The architectural
// accum/carry/zero only change when an op completes.
module alu_seq_acc
  import alu_seq_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int MUL_EN = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [WIDTH-1:0]    data,
  output logic [WIDTH-1:0]    accum,
  output logic                carry,
  output logic                zero,
  output logic                out_valid,
  output logic                busy
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH + 1);

  state_t             state;
  state_t             state_nxt;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      cnt_nxt;

  opcode_t            op;
  logic [SHW-1:0]     shamt;
  logic               accept;
  logic               start_shift;
  logic               start_mul;
  logic               cnt_last;

  logic [WIDTH-1:0]   core_accum;
  logic               core_carry;

  // Working registers: never visible on the ports.
  logic               shr_dir;
  logic [WIDTH-1:0]   work;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;

  logic [WIDTH-1:0]   shf_nxt;
  logic               shf_out;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod_nxt;

  logic               vld_p0;
  logic [WIDTH-1:0]   res_accum_p0;
  logic               res_carry_p0;

  assign op          = opcode_t'(opcode);
  assign shamt       = data[SHW-1:0];
  assign in_ready    = (state == IDLE);
  assign busy        = ~in_ready;
  assign accept      = in_valid && in_ready;
  assign start_shift = accept && is_shift(op) && (shamt != '0);
  assign start_mul   = accept && (op == OP_MUL) && (MUL_EN != 0);
  assign cnt_last    = (cnt == CW'(1));

  alu_seq_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .opcode    (opcode),
    .accum     (accum),
    .data      (data),
    .carry     (carry),
    .nxt_accum (core_accum),
    .nxt_carry (core_carry)
  );

  // One shift step; carry takes the bit that falls off the end.
  always_comb begin
    if (shr_dir) begin
      shf_nxt = {1'b0, work[WIDTH-1:1]};
      shf_out = work[0];
    end else begin
      shf_nxt = {work[WIDTH-2:0], 1'b0};
      shf_out = work[WIDTH-1];
    end
  end

  // One shift-add step: multiplier sits in the low half of prod and is
  // consumed LSB first while partial sums shift in from the top.
  always_comb begin
    mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_nxt = {mul_sum, prod[WIDTH-1:1]};
  end

  // Next-state, counter and completion result.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    vld_p0       = 1'b0;
    res_accum_p0 = accum;
    res_carry_p0 = carry;
    case (state)
      IDLE: begin
        if (start_shift) begin
          state_nxt = SHIFT;
          cnt_nxt   = CW'(shamt);
        end else if (start_mul) begin
          state_nxt = MUL;
          cnt_nxt   = CW'(WIDTH);
        end else if (accept) begin
          vld_p0       = 1'b1;
          res_accum_p0 = core_accum;
          res_carry_p0 = core_carry;
        end
      end
      SHIFT: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt_last) begin
          state_nxt    = IDLE;
          vld_p0       = 1'b1;
          res_accum_p0 = shf_nxt;
          res_carry_p0 = shf_out;
        end
      end
      MUL: begin
        cnt_nxt = cnt - CW'(1);
        if (cnt_last) begin
          state_nxt    = IDLE;
          vld_p0       = 1'b1;
          res_accum_p0 = prod_nxt[WIDTH-1:0];
          res_carry_p0 = |prod_nxt[2*WIDTH-1:WIDTH];
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p0 -> p1: architectural state and completion pulse ----
  // State register, iteration counter and flags; reset aborts any op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      accum     <= '0;
      carry     <= 1'b0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      out_valid <= vld_p0;
      if (vld_p0) begin
        accum <= res_accum_p0;
        carry <= res_carry_p0;
        zero  <= (res_accum_p0 == '0);
      end
    end
  end

  // Working registers: loaded on entry to SHIFT/MUL, stepped each cycle there.
  always_ff @(posedge clk) begin
    if (start_shift) begin
      work    <= accum;
      shr_dir <= (op == OP_SHR);
    end else if (state == SHIFT) begin
      work <= shf_nxt;
    end
    if (start_mul) begin
      mcand <= accum;
      prod  <= {{WIDTH{1'b0}}, data};
    end else if (state == MUL) begin
      prod <= prod_nxt;
    end
  end

endmodule
